// File: rtl/usr_pkg.sv
// Shared types and helpers for the parametrised universal shift register.
// Command modes, sequencer states and the effective-shift-amount rule.
package usr_pkg;

  typedef enum logic [2:0] {
    M_SLL = 3'd0,
    M_SRL = 3'd1,
    M_SRA = 3'd2,
    M_ROL = 3'd3,
    M_ROR = 3'd4,
    M_SLS = 3'd5,
    M_SRS = 3'd6,
    M_NOP = 3'd7
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam mode_e MODE_NOP = M_NOP;

  // Shifts saturate at the register width, rotates keep the full count, NOP is zero.
  function automatic int unsigned eff_amt(input logic [2:0] mode, input int unsigned amt,
                                          input int unsigned width);
    int unsigned n;
    case (mode)
      M_ROL, M_ROR: n = amt;
      MODE_NOP:     n = 32'd0;
      default:      n = (amt > width) ? width : amt;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational shift datapath. Default build: one bit per call.
// With USR_BARREL_EN defined: full log2 barrel shift by the requested amount.
module usr_step
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8
`ifdef USR_BARREL_EN
  , localparam int AMT_W = $clog2(WIDTH) + 1
`endif
) (
  input  logic [WIDTH-1:0] op_i,
  input  logic [2:0]       mode_i,
  input  logic             ser_in_i,
`ifdef USR_BARREL_EN
  input  logic [AMT_W-1:0] amt_i,
`endif
  output logic [WIDTH-1:0] next_op_o,
  output logic             out_bit_o
);

`ifdef USR_BARREL_EN
  localparam int IDX_W = $clog2(WIDTH);

  logic                      left_s;
  logic                      rot_s;
  logic                      fill_s;
  logic [AMT_W-1:0]          n_s;
  logic [IDX_W-1:0]          idx_s;
  logic [AMT_W:0][WIDTH-1:0] stage_s;

  assign left_s = (mode_i == M_SLL) || (mode_i == M_ROL) || (mode_i == M_SLS);
  assign rot_s  = (mode_i == M_ROL) || (mode_i == M_ROR);
  assign n_s    = rot_s ? AMT_W'(32'(amt_i) % 32'(WIDTH))
                        : AMT_W'(eff_amt(mode_i, 32'(amt_i), 32'(WIDTH)));

  // Fill bit is constant across all stages; SRA keeps the original sign.
  always_comb begin
    case (mode_i)
      M_SRA:        fill_s = op_i[WIDTH-1];
      M_SLS, M_SRS: fill_s = ser_in_i;
      default:      fill_s = 1'b0;
    endcase
  end

  assign stage_s[0] = op_i;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int S = 1 << k;
    localparam int R = S % WIDTH;
    logic [WIDTH-1:0] shl_s, shr_s, rol_s, ror_s;
    if (S < WIDTH) begin : g_shift
      assign shl_s = {stage_s[k][WIDTH-1-S:0], {S{fill_s}}};
      assign shr_s = {{S{fill_s}}, stage_s[k][WIDTH-1:S]};
    end else begin : g_flush
      assign shl_s = {WIDTH{fill_s}};
      assign shr_s = {WIDTH{fill_s}};
    end
    if (R == 0) begin : g_rot0
      assign rol_s = stage_s[k];
      assign ror_s = stage_s[k];
    end else begin : g_rot
      assign rol_s = {stage_s[k][WIDTH-1-R:0], stage_s[k][WIDTH-1:WIDTH-R]};
      assign ror_s = {stage_s[k][R-1:0], stage_s[k][WIDTH-1:R]};
    end
    assign stage_s[k+1] = !n_s[k] ? stage_s[k] :
                          rot_s   ? (left_s ? rol_s : ror_s) :
                                    (left_s ? shl_s : shr_s);
  end

  assign next_op_o = stage_s[AMT_W];

  // Reproduce the last bit the serial sequencer would have pushed out.
  always_comb begin
    idx_s     = IDX_W'(0);
    out_bit_o = 1'b0;
    case (mode_i)
      M_SLL, M_SLS: begin
        idx_s     = IDX_W'(32'(WIDTH) - 32'(n_s));
        out_bit_o = op_i[idx_s];
      end
      M_SRL, M_SRA, M_SRS: begin
        idx_s     = IDX_W'(32'(n_s) - 32'd1);
        out_bit_o = op_i[idx_s];
      end
      M_ROL:   out_bit_o = stage_s[AMT_W][0];
      M_ROR:   out_bit_o = stage_s[AMT_W][WIDTH-1];
      default: out_bit_o = 1'b0;
    endcase
  end
`else
  // Single-bit step in the requested direction with the mode's fill bit.
  always_comb begin
    next_op_o = op_i;
    out_bit_o = 1'b0;
    case (mode_i)
      M_SLL: begin next_op_o = {op_i[WIDTH-2:0], 1'b0};          out_bit_o = op_i[WIDTH-1]; end
      M_SRL: begin next_op_o = {1'b0, op_i[WIDTH-1:1]};          out_bit_o = op_i[0];       end
      M_SRA: begin next_op_o = {op_i[WIDTH-1], op_i[WIDTH-1:1]}; out_bit_o = op_i[0];       end
      M_ROL: begin next_op_o = {op_i[WIDTH-2:0], op_i[WIDTH-1]}; out_bit_o = op_i[WIDTH-1]; end
      M_ROR: begin next_op_o = {op_i[0], op_i[WIDTH-1:1]};       out_bit_o = op_i[0];       end
      M_SLS: begin next_op_o = {op_i[WIDTH-2:0], ser_in_i};      out_bit_o = op_i[WIDTH-1]; end
      M_SRS: begin next_op_o = {ser_in_i, op_i[WIDTH-1:1]};      out_bit_o = op_i[0];       end
      default: begin next_op_o = op_i;                           out_bit_o = 1'b0;          end
    endcase
  end
`endif

endmodule

// File: rtl/param_univ_shift_reg.sv
// Parametrised universal shift register with start/busy/done command handshake.
// Define USR_BARREL_EN to execute each command in one cycle through a barrel shifter.
module param_univ_shift_reg
  import usr_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_a,
  input  logic [WIDTH-1:0] ip,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic             ser_in,
  input  logic             abort,
  output logic [WIDTH-1:0] op,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] op_q;
  logic [WIDTH-1:0] step_op_d;
  logic             ser_q;
  logic             busy_q;
  logic             done_q;
  logic             step_bit_d;
  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] eff_s;

  assign eff_s = AMT_W'(eff_amt(mode, 32'(amt), 32'(WIDTH)));

`ifdef USR_BARREL_EN
  usr_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (op_q),
    .mode_i    (mode),
    .ser_in_i  (ser_in),
    .amt_i     (amt),
    .next_op_o (step_op_d),
    .out_bit_o (step_bit_d)
  );
`else
  logic [2:0] mode_q;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .op_i      (op_q),
    .mode_i    (mode_q),
    .ser_in_i  (ser_in),
    .next_op_o (step_op_d),
    .out_bit_o (step_bit_d)
  );
`endif

  // Command sequencer; all outputs come straight from its registers.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= ST_IDLE;
      op_q    <= {WIDTH{1'b0}};
      ser_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= {AMT_W{1'b0}};
`ifndef USR_BARREL_EN
      mode_q  <= M_SLL;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            op_q <= ip;
          end else if (start) begin
`ifdef USR_BARREL_EN
            op_q <= step_op_d;
            if (eff_s != {AMT_W{1'b0}}) ser_q <= step_bit_d;
            state_q <= ST_DONE;
            done_q  <= 1'b1;
`else
            mode_q <= mode;
            cnt_q  <= eff_s;
            if (eff_s != {AMT_W{1'b0}}) begin
              state_q <= ST_SHIFT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
`endif
          end
        end
        ST_SHIFT: begin
`ifdef USR_BARREL_EN
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`else
          if (abort) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            op_q  <= step_op_d;
            ser_q <= step_bit_d;
            cnt_q <= cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`endif
        end
        ST_DONE: state_q <= ST_IDLE;
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign op      = op_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Self-checking bench for param_univ_shift_reg (WIDTH=8), serial or USR_BARREL_EN build.
// Directed vector table, hand-written corner sequences and a random phase against a reference model.
module tb_param_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst_a;
  logic [7:0] ip;
  logic       load, start, ser_in, abort;
  logic [2:0] mode;
  logic [3:0] amt;
  logic [7:0] op;
  logic       ser_out, busy, done;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] op;
    logic       ser;
    int         lat;
    int         bsy;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [7:0] init;
    logic [2:0] m;
    logic [3:0] a;
    logic       si;
    logic [7:0] eop;
    logic       eser;
  } vec_t;
  vec_t tbl[13];

  logic shadow_ser;

  param_univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst_a(rst_a), .ip(ip), .load(load), .start(start), .mode(mode),
    .amt(amt), .ser_in(ser_in), .abort(abort), .op(op), .ser_out(ser_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bench_eff(input logic [2:0] m, input int a);
    if (m == 3'd3 || m == 3'd4) return a;
    if (m == 3'd7) return 0;
    return (a > 8) ? 8 : a;
  endfunction

  // Reference result built from whole-word operators, not from single steps.
  function automatic void model(input logic [7:0] x, input logic [2:0] m, input int a,
                                input logic si, input logic sprev,
                                output logic [7:0] r, output logic so);
    int n;
    logic [15:0] t;
    n  = bench_eff(m, a);
    r  = x;
    so = sprev;
    t  = 16'h0000;
    if (n != 0) begin
      case (m)
        3'd0: begin t = {8'h00, x} << n; r = t[7:0]; so = t[8]; end
        3'd5: begin
          t = ({8'h00, x} << n) | (si ? ((16'h0001 << n) - 16'h0001) : 16'h0000);
          r = t[7:0]; so = t[8];
        end
        3'd1: begin t = {x, 8'h00} >> n; r = t[15:8]; so = t[7]; end
        3'd6: begin
          t = ({x, 8'h00} >> n) | (si ? ~(16'hFFFF >> n) : 16'h0000);
          r = t[15:8]; so = t[7];
        end
        3'd2: begin t = 16'($signed({x, 8'h00}) >>> n); r = t[15:8]; so = t[7]; end
        3'd3: begin t = {x, x} << (n % 8); r = t[15:8]; so = r[0]; end
        3'd4: begin t = {x, x} >> (n % 8); r = t[7:0];  so = r[7]; end
        default: begin r = x; so = sprev; end
      endcase
    end
  endfunction

  task automatic do_load(input logic [7:0] v);
    ip = v; load = 1'b1;
    tick();
    load = 1'b0;
    check("load", {24'h0, op}, {24'h0, v});
  endtask

  // Issue one command, wait (bounded) for done, then score op/ser_out/timing.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] a, input logic si,
                         input logic [7:0] eop, input logic eser, input bit disturb);
    exp_t e, got;
    int lat, bsy, eff;
    eff   = bench_eff(m, int'(a));
    e.op  = eop;
    e.ser = eser;
`ifdef USR_BARREL_EN
    e.lat = 1;
    e.bsy = 0;
`else
    e.lat = (eff == 0) ? 1 : eff + 1;
    e.bsy = eff;
`endif
    mode = m; amt = a; ser_in = si; start = 1'b1;
    sb.push_back(e);
    tick();
    start = 1'b0;
    lat = 1;
    bsy = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bsy++;
      if (disturb && lat == 2) begin
        ip = 8'hA5; load = 1'b1; start = 1'b1; mode = 3'd4; amt = 4'd1;
      end
      tick();
      load = 1'b0; start = 1'b0;
      lat++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'h0, 32'h1);
    end else begin
      got = sb.pop_front();
      check("op",      {24'h0, op}, {24'h0, got.op});
      check("ser_out", {31'h0, ser_out}, {31'h0, got.ser});
      check("latency", lat, got.lat);
      check("busy_cycles", bsy, got.bsy);
    end
    tick();
    check("done_pulse", {31'h0, done}, 32'h0);
    check("busy_after", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    logic [7:0] r_init, r_op;
    logic [2:0] r_m;
    logic [3:0] r_a;
    logic       r_si, r_so, flag;

    tbl[0]  = '{8'hCC, 3'd3, 4'd3,  1'b0, 8'h66, 1'b0};
    tbl[1]  = '{8'h8C, 3'd2, 4'd2,  1'b0, 8'hE3, 1'b0};
    tbl[2]  = '{8'hE3, 3'd1, 4'd9,  1'b0, 8'h00, 1'b1};
    tbl[3]  = '{8'hAD, 3'd5, 4'd4,  1'b1, 8'hDF, 1'b0};
    tbl[4]  = '{8'hDF, 3'd6, 4'd4,  1'b0, 8'h0D, 1'b1};
    tbl[5]  = '{8'hF0, 3'd4, 4'd8,  1'b0, 8'hF0, 1'b1};
    tbl[6]  = '{8'h81, 3'd0, 4'd1,  1'b0, 8'h02, 1'b1};
    tbl[7]  = '{8'h81, 3'd1, 4'd1,  1'b0, 8'h40, 1'b1};
    tbl[8]  = '{8'h5A, 3'd3, 4'd12, 1'b0, 8'hA5, 1'b1};
    tbl[9]  = '{8'h80, 3'd2, 4'd8,  1'b0, 8'hFF, 1'b1};
    tbl[10] = '{8'h97, 3'd0, 4'd15, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{8'h3C, 3'd4, 4'd3,  1'b0, 8'h87, 1'b1};
    tbl[12] = '{8'h01, 3'd5, 4'd7,  1'b1, 8'hFF, 1'b0};

    rst_a = 1'b0; ip = 8'h00; load = 1'b0; start = 1'b0; mode = 3'd0;
    amt = 4'd0; ser_in = 1'b0; abort = 1'b0;
    tick(); tick();
    check("rst_op",   {24'h0, op}, 32'h0);
    check("rst_ser",  {31'h0, ser_out}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    rst_a = 1'b1;
    tick();

    // Reset in the middle of a running SLL.
    do_load(8'hFF);
    mode = 3'd0; amt = 4'd6; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst_a = 1'b0;
    #1;
    check("midrst_op",   {24'h0, op}, 32'h0);
    check("midrst_ser",  {31'h0, ser_out}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    tick();
    rst_a = 1'b1;
    flag = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) flag = 1'b1;
    end
    check("midrst_no_done", {31'h0, flag}, 32'h0);
    shadow_ser = 1'b0;

    for (int i = 0; i < 13; i++) begin
      do_load(tbl[i].init);
      run_cmd(tbl[i].m, tbl[i].a, tbl[i].si, tbl[i].eop, tbl[i].eser, 1'b0);
      shadow_ser = tbl[i].eser;
    end

    // load and start together: load wins, command is dropped.
    do_load(8'h12);
    ip = 8'h34; load = 1'b1; start = 1'b1; mode = 3'd0; amt = 4'd2;
    tick();
    load = 1'b0; start = 1'b0;
    check("ldst_op", {24'h0, op}, 32'h34);
    flag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (busy === 1'b1 || done === 1'b1) flag = 1'b1;
      tick();
    end
    check("ldst_no_cmd", {31'h0, flag}, 32'h0);
    check("ldst_op_hold", {24'h0, op}, 32'h34);

    // load/start while busy are ignored (0x34 << 4 = 0x40, last out bit 1).
    run_cmd(3'd0, 4'd4, 1'b0, 8'h40, 1'b1, 1'b1);
    shadow_ser = 1'b1;

    // NOP and amt=0 complete at once, op and ser_out untouched.
    do_load(8'h5C);
    run_cmd(3'd7, 4'd5, 1'b0, 8'h5C, shadow_ser, 1'b0);
    run_cmd(3'd1, 4'd0, 1'b1, 8'h5C, shadow_ser, 1'b0);

    // abort in IDLE has no effect.
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("idle_abort_op", {24'h0, op}, 32'h5C);
    check("idle_abort_done", {31'h0, done}, 32'h0);

`ifndef USR_BARREL_EN
    // Abort after three ROR steps, then a full eight-step ROR.
    do_load(8'hF0);
    mode = 3'd4; amt = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("abort_partial", {24'h0, op}, 32'h1E);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_op",   {24'h0, op}, 32'h1E);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    tick();
    check("abort_no_done", {31'h0, done}, 32'h0);
    check("abort_ser", {31'h0, ser_out}, 32'h0);
    run_cmd(3'd4, 4'd8, 1'b0, 8'h1E, 1'b0, 1'b0);
    shadow_ser = 1'b0;
`endif

    for (int i = 0; i < 24; i++) begin
      r_init = 8'($urandom);
      r_m    = 3'($urandom_range(0, 7));
      r_a    = 4'($urandom_range(0, 15));
      r_si   = 1'($urandom_range(0, 1));
      model(r_init, r_m, int'(r_a), r_si, shadow_ser, r_op, r_so);
      do_load(r_init);
      run_cmd(r_m, r_a, r_si, r_op, r_so, (i % 3) == 0);
      shadow_ser = r_so;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
